mmio_periph_hub: RTL and testbench
==================================

Name: mmio_periph_hub

Overview:
- Parametrised successor to the top-level MMIO decode/register logic.
- Sits between memmap's MMIO port and the peripherals (uartwriter, display_controller).
- Adds NUM_DISP display registers, a registered read-response FSM, and a prescaled timer with compare-match interrupt.
- Unmapped accesses are acknowledged and flagged, never stalled.

Parameters:
- DATA_WIDTH, 32: MMIO data width.
- NUM_DISP, 3: number of 8-bit display registers, 1..8.
- TIMER_WIDTH, 32: timer counter/compare width, ≤ DATA_WIDTH.
- PRESCALE, 50: clock cycles per timer tick, ≥ 1.
- TX_FIFO_DEPTH, 4: log2 of UART TX FIFO depth; i_uart_tx_free width is TX_FIFO_DEPTH+1.

Ports:
- i_clk  in  1  clock; the block's only clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_addr  in  32  MMIO address; bits [15:0] decoded.
- i_data  in  DATA_WIDTH  write data.
- i_wr_valid  in  1  write request.
- o_wr_ready  out  1  write accepted this cycle.
- o_data  out  DATA_WIDTH  read data, registered.
- o_rd_valid  out  1  read data valid.
- i_rd_ready  in  1  read request; held until o_rd_valid.
- o_uart_data  out  8  TX byte.
- o_uart_wr_valid  out  1  TX push.
- i_uart_wr_ready  in  1  TX FIFO accepts the byte.
- i_uart_tx_free  in  TX_FIFO_DEPTH+1  free TX slots.
- i_uart_rx_present  in  1  RX byte available.
- i_uart_data  in  8  RX byte.
- i_uart_rd_valid  in  1  RX byte valid.
- o_uart_rd_ready  out  1  RX pop.
- o_disp_regs  out  NUM_DISP*8  display registers, reg k at bits [8k+7:8k].
- o_timer_irq  out  1  timer interrupt, level.
- o_unmapped  out  1  one-cycle pulse on access to an unmapped address.

Behaviour:
- Reset (async): o_data=0, o_rd_valid=0, o_disp_regs=0, o_timer_irq=0, o_unmapped=0, FSM=IDLE; timer count, compare, ctrl, flag and prescaler all 0.
- Address map, addr[15:0]:
  - FFFF: UART TX. Write passes through; read returns tx_free, zero-extended.
  - FFFE: UART RX data, read-only.
  - FFFD: RX present, read-only.
  - FFF0+k, k<NUM_DISP: display register k, RW.
  - FFE0: timer count. Write loads the count.
  - FFE1: compare.
  - FFE2: ctrl. bit0 enable, bit1 auto-reload, bit2 irq_en.
  - FFE3: status. bit0 match flag; write 1 clears.
  - All other addresses are unmapped.
- Writes, combinational ack:
  - FFFF: o_uart_data=i_data[7:0], o_uart_wr_valid=i_wr_valid, o_wr_ready=i_uart_wr_ready.
  - Local registers and unmapped: o_wr_ready=i_wr_valid; the register updates on that edge. Unmapped writes are dropped and pulse o_unmapped.
  - Writes to read-only addresses are acknowledged and ignored.
- Read FSM states: IDLE, RX_WAIT, RESP.
  - IDLE, i_rd_ready, addr FFFE: go to RX_WAIT, with o_uart_rd_ready=1 combinationally in RX_WAIT.
  - RX_WAIT, i_uart_rd_valid: capture the byte into o_data, go to RESP. Otherwise stay; no timeout.
  - IDLE, i_rd_ready, any other address: capture read data into o_data, go to RESP. Unmapped reads return 0 and pulse o_unmapped.
  - RESP: o_rd_valid=1 for exactly one cycle, then IDLE.
  - Read latency: 1 cycle for local registers; 1 cycle after i_uart_rd_valid for RX.
  - i_rd_ready and i_wr_valid together: write is serviced, read is ignored. memmap never issues both.
- Timer:
  - Prescaler counts 0..PRESCALE-1 while enabled. On wrap it issues a tick and count increments, wrapping modulo 2^TIMER_WIDTH.
  - Disabling holds count and resets the prescaler.
  - On a tick where the pre-increment count == compare: set flag. With auto-reload, the next count is 0 instead of count+1.
  - o_timer_irq = flag & irq_en, registered, 1-cycle lag.
  - Count write and tick in the same cycle: the write wins.
  - Flag clear and new match in the same cycle: set wins.
  - Compare write takes effect on the next tick.
- Reset asserted mid-transaction: FSM returns to IDLE immediately and no o_rd_valid is issued. The requester must re-issue.

Decomposition:
- Package mmio_hub_pkg holds:
  - address constants;
  - ctrl/status bit indices;
  - the read-FSM state enum;
  - helper function is_disp_addr(addr, NUM_DISP).
- Sub-module mmio_timer (TIMER_WIDTH, PRESCALE) holds the prescaler, count, compare, ctrl and flag, with write strobes and irq output. The hub instantiates it and muxes its read-back.

Test Plan:
- Write 0xA5 to FFF1, then read FFF1 → o_wr_ready same cycle, o_disp_regs[15:8]=A5, o_rd_valid one cycle later with o_data=0xA5.
- Read FFFE with i_uart_rd_valid held low for 5 cycles, then high with i_uart_data=0x3C → o_uart_rd_ready high throughout the wait, o_rd_valid the cycle after, o_data=0x3C.
- PRESCALE=4, compare=3, ctrl=0b111 → flag set on the 4th tick, count reloads to 0, o_timer_irq rises one cycle later. Writing 1 to FFE3 clears irq.
- Write FFE0 on the same cycle as a tick → count equals the written value, with no increment.
- Write FFFF with i_uart_wr_ready=0 for 3 cycles, then 1 → o_wr_ready mirrors i_uart_wr_ready, byte presented throughout.
- Read 0x1234 and FFF0+NUM_DISP → o_data=0, o_rd_valid after 1 cycle, o_unmapped pulses once each. Assert i_rst during RESP → o_rd_valid=0 immediately.

Source files
------------

// File: rtl/mmio_hub_pkg.sv
// rtl/mmio_hub_pkg.sv - shared address map, bit indices and read-FSM states for the MMIO hub
package mmio_hub_pkg;

    localparam logic [15:0] ADDR_UART_TX    = 16'hFFFF;
    localparam logic [15:0] ADDR_UART_RX    = 16'hFFFE;
    localparam logic [15:0] ADDR_RX_PRESENT = 16'hFFFD;
    localparam logic [15:0] ADDR_DISP_BASE  = 16'hFFF0;
    localparam logic [15:0] ADDR_TMR_COUNT  = 16'hFFE0;
    localparam logic [15:0] ADDR_TMR_CMP    = 16'hFFE1;
    localparam logic [15:0] ADDR_TMR_CTRL   = 16'hFFE2;
    localparam logic [15:0] ADDR_TMR_STATUS = 16'hFFE3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_AR_BIT     = 1;
    localparam int CTRL_IE_BIT     = 2;
    localparam int STATUS_FLAG_BIT = 0;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RX_WAIT,
        RD_RESP
    } rd_state_e;

    function automatic logic is_disp_addr(input logic [15:0] addr, input int num_disp);
        logic [15:0] off;
        off = addr - ADDR_DISP_BASE;
        return (addr >= ADDR_DISP_BASE) && (int'(off) < num_disp);
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - prescaled up-counter with compare match, auto-reload and level interrupt
module mmio_timer
    import mmio_hub_pkg::*;
#(
    parameter int TIMER_WIDTH = 32,
    parameter int PRESCALE    = 50
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_count_we,
    input  logic                   i_cmp_we,
    input  logic                   i_ctrl_we,
    input  logic                   i_status_we,
    input  logic [TIMER_WIDTH-1:0] i_wdata,
    input  logic [2:0]             i_wbits,
    output logic [TIMER_WIDTH-1:0] o_count,
    output logic [TIMER_WIDTH-1:0] o_compare,
    output logic [2:0]             o_ctrl,
    output logic                   o_flag,
    output logic                   o_irq
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]          presc_q, presc_d;
    logic [TIMER_WIDTH-1:0] count_q, count_d;
    logic [TIMER_WIDTH-1:0] cmp_q, cmp_d;
    logic [2:0]             ctrl_q, ctrl_d;
    logic                   flag_q, flag_d;
    logic                   irq_q, irq_d;
    logic                   tick, match;

    always_comb begin
        tick    = ctrl_q[CTRL_EN_BIT] && (presc_q == PRESC_LAST);
        match   = tick && (count_q == cmp_q);
        presc_d = '0;
        if (ctrl_q[CTRL_EN_BIT]) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        // A software load of the count overrides whatever the tick would have produced
        count_d = count_q;
        if (i_count_we) begin
            count_d = i_wdata;
        end else if (tick) begin
            count_d = (match && ctrl_q[CTRL_AR_BIT]) ? '0 : count_q + 1'b1;
        end
        cmp_d  = i_cmp_we ? i_wdata : cmp_q;
        ctrl_d = i_ctrl_we ? i_wbits : ctrl_q;
        flag_d = flag_q;
        if (i_status_we && i_wbits[STATUS_FLAG_BIT]) begin
            flag_d = 1'b0;
        end
        if (match) begin
            flag_d = 1'b1;
        end
        irq_d = flag_q & ctrl_q[CTRL_IE_BIT];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc_q <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            ctrl_q  <= '0;
            flag_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            flag_q  <= flag_d;
            irq_q   <= irq_d;
        end
    end

    assign o_count   = count_q;
    assign o_compare = cmp_q;
    assign o_ctrl    = ctrl_q;
    assign o_flag    = flag_q;
    assign o_irq     = irq_q;

endmodule

// File: rtl/mmio_periph_hub.sv
// rtl/mmio_periph_hub.sv - MMIO decode, display registers, registered read response and timer hookup
module mmio_periph_hub
    import mmio_hub_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_DISP      = 3,
    parameter int TIMER_WIDTH   = 32,
    parameter int PRESCALE      = 50,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [31:0]              i_addr,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_wr_valid,
    output logic                     o_wr_ready,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [7:0]               o_uart_data,
    output logic                     o_uart_wr_valid,
    input  logic                     i_uart_wr_ready,
    input  logic [TX_FIFO_DEPTH:0]   i_uart_tx_free,
    input  logic                     i_uart_rx_present,
    input  logic [7:0]               i_uart_data,
    input  logic                     i_uart_rd_valid,
    output logic                     o_uart_rd_ready,
    output logic [NUM_DISP*8-1:0]    o_disp_regs,
    output logic                     o_timer_irq,
    output logic                     o_unmapped
);
    logic [15:0]            addr;
    logic                   is_tx, mapped, local_we, wr_unmapped, rd_unmapped;
    logic [DATA_WIDTH-1:0]  rdata;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [NUM_DISP*8-1:0]  disp_q, disp_d;
    rd_state_e              state_q, state_d;
    logic                   unmapped_q, unmapped_d;
    logic [TIMER_WIDTH-1:0] t_count, t_compare;
    logic [2:0]             t_ctrl;
    logic                   t_flag, t_irq;
    logic                   unused_bits;

    assign addr        = i_addr[15:0];
    assign unused_bits = ^{i_addr[31:16], i_data};

    assign is_tx  = (addr == ADDR_UART_TX);
    assign mapped = is_tx || (addr == ADDR_UART_RX) || (addr == ADDR_RX_PRESENT)
                 || is_disp_addr(addr, NUM_DISP)
                 || (addr == ADDR_TMR_COUNT) || (addr == ADDR_TMR_CMP)
                 || (addr == ADDR_TMR_CTRL) || (addr == ADDR_TMR_STATUS);

    // TX writes are backpressured by the UART FIFO; everything else acks immediately
    assign o_uart_data     = i_data[7:0];
    assign o_uart_wr_valid = i_wr_valid && is_tx;
    assign o_wr_ready      = is_tx ? i_uart_wr_ready : i_wr_valid;
    assign local_we        = i_wr_valid && !is_tx;
    assign wr_unmapped     = i_wr_valid && !mapped;

    always_comb begin
        disp_d = disp_q;
        for (int k = 0; k < NUM_DISP; k++) begin
            if (local_we && (addr == ADDR_DISP_BASE + 16'(k))) begin
                disp_d[8*k +: 8] = i_data[7:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (is_tx) begin
            rdata = DATA_WIDTH'(i_uart_tx_free);
        end else if (addr == ADDR_RX_PRESENT) begin
            rdata = DATA_WIDTH'(i_uart_rx_present);
        end else if (addr == ADDR_TMR_COUNT) begin
            rdata = DATA_WIDTH'(t_count);
        end else if (addr == ADDR_TMR_CMP) begin
            rdata = DATA_WIDTH'(t_compare);
        end else if (addr == ADDR_TMR_CTRL) begin
            rdata = DATA_WIDTH'(t_ctrl);
        end else if (addr == ADDR_TMR_STATUS) begin
            rdata = DATA_WIDTH'(t_flag);
        end
        for (int k = 0; k < NUM_DISP; k++) begin
            if (addr == ADDR_DISP_BASE + 16'(k)) begin
                rdata = DATA_WIDTH'(disp_q[8*k +: 8]);
            end
        end
    end

    mmio_timer #(
        .TIMER_WIDTH(TIMER_WIDTH),
        .PRESCALE   (PRESCALE)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_count_we (local_we && (addr == ADDR_TMR_COUNT)),
        .i_cmp_we   (local_we && (addr == ADDR_TMR_CMP)),
        .i_ctrl_we  (local_we && (addr == ADDR_TMR_CTRL)),
        .i_status_we(local_we && (addr == ADDR_TMR_STATUS)),
        .i_wdata    (i_data[TIMER_WIDTH-1:0]),
        .i_wbits    (i_data[2:0]),
        .o_count    (t_count),
        .o_compare  (t_compare),
        .o_ctrl     (t_ctrl),
        .o_flag     (t_flag),
        .o_irq      (t_irq)
    );

    // A simultaneous write wins the cycle, so a read is only started with no write present
    always_comb begin
        state_d         = state_q;
        data_d          = data_q;
        rd_unmapped     = 1'b0;
        o_uart_rd_ready = 1'b0;
        o_rd_valid      = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (i_rd_ready && !i_wr_valid) begin
                    if (addr == ADDR_UART_RX) begin
                        state_d = RD_RX_WAIT;
                    end else begin
                        data_d      = rdata;
                        rd_unmapped = !mapped;
                        state_d     = RD_RESP;
                    end
                end
            end
            RD_RX_WAIT: begin
                o_uart_rd_ready = 1'b1;
                if (i_uart_rd_valid) begin
                    data_d  = DATA_WIDTH'(i_uart_data);
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                o_rd_valid = 1'b1;
                state_d    = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase
        unmapped_d = wr_unmapped || rd_unmapped;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= RD_IDLE;
            data_q     <= '0;
            disp_q     <= '0;
            unmapped_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            disp_q     <= disp_d;
            unmapped_q <= unmapped_d;
        end
    end

    assign o_data      = data_q;
    assign o_disp_regs = disp_q;
    assign o_unmapped  = unmapped_q;
    assign o_timer_irq = t_irq;

endmodule

// File: tb/tb_mmio_periph_hub.sv
// tb/tb_mmio_periph_hub.sv - directed and randomized checks of mmio_periph_hub against a behavioural model
module tb_mmio_periph_hub;
    localparam int DW  = 32;
    localparam int ND  = 3;
    localparam int TW  = 16;
    localparam int PS  = 4;
    localparam int TFD = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [31:0]   i_addr;
    logic [DW-1:0] i_data;
    logic          i_wr_valid;
    logic          o_wr_ready;
    logic [DW-1:0] o_data;
    logic          o_rd_valid;
    logic          i_rd_ready;
    logic [7:0]    o_uart_data;
    logic          o_uart_wr_valid;
    logic          i_uart_wr_ready;
    logic [TFD:0]  i_uart_tx_free;
    logic          i_uart_rx_present;
    logic [7:0]    i_uart_data;
    logic          i_uart_rd_valid;
    logic          o_uart_rd_ready;
    logic [ND*8-1:0] o_disp_regs;
    logic          o_timer_irq;
    logic          o_unmapped;

    mmio_periph_hub #(
        .DATA_WIDTH(DW), .NUM_DISP(ND), .TIMER_WIDTH(TW), .PRESCALE(PS), .TX_FIFO_DEPTH(TFD)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_data(i_data),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .o_data(o_data),
        .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_uart_data(o_uart_data),
        .o_uart_wr_valid(o_uart_wr_valid), .i_uart_wr_ready(i_uart_wr_ready),
        .i_uart_tx_free(i_uart_tx_free), .i_uart_rx_present(i_uart_rx_present),
        .i_uart_data(i_uart_data), .i_uart_rd_valid(i_uart_rd_valid),
        .o_uart_rd_ready(o_uart_rd_ready), .o_disp_regs(o_disp_regs),
        .o_timer_irq(o_timer_irq), .o_unmapped(o_unmapped)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the hub state
    logic [7:0]  m_disp [ND];
    logic [15:0] m_cnt = 0, m_cmp = 0;
    bit          m_en = 0, m_ar = 0, m_ie = 0, m_flag = 0, m_irq = 0;
    int          m_presc = 0;
    bit          m_wait_rx = 0, m_resp = 0, m_unm = 0;
    logic [31:0] m_data = 0;

    function automatic bit m_mapped(input logic [15:0] a);
        int ai = int'(a);
        return (ai >= 'hFFFD) || (ai >= 'hFFF0 && ai < 'hFFF0 + ND) || (ai >= 'hFFE0 && ai <= 'hFFE3);
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        int ai = int'(a);
        if (ai >= 'hFFF0 && ai < 'hFFF0 + ND) return 32'(m_disp[ai - 'hFFF0]);
        case (a)
            16'hFFFF: return 32'(i_uart_tx_free);
            16'hFFFD: return 32'(i_uart_rx_present);
            16'hFFE0: return 32'(m_cnt);
            16'hFFE1: return 32'(m_cmp);
            16'hFFE2: return {29'd0, m_ie, m_ar, m_en};
            16'hFFE3: return 32'(m_flag);
            default:  return 32'd0;
        endcase
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        logic [15:0] ma;
        logic [31:0] rv;
        bit wr, mp, tick, hit, nirq, unm;
        int idx;
        if (i_rst) begin
            for (int k = 0; k < ND; k++) m_disp[k] = 8'd0;
            m_cnt = 0; m_cmp = 0; m_en = 0; m_ar = 0; m_ie = 0; m_flag = 0; m_irq = 0;
            m_presc = 0; m_wait_rx = 0; m_resp = 0; m_unm = 0; m_data = 0;
        end else begin
            ma   = i_addr[15:0];
            wr   = i_wr_valid;
            rv   = m_read(ma);
            mp   = m_mapped(ma);
            tick = m_en && (m_presc == PS - 1);
            hit  = tick && (m_cnt == m_cmp);
            nirq = m_flag && m_ie;
            m_presc = !m_en ? 0 : (tick ? 0 : m_presc + 1);
            if (tick) m_cnt = (hit && m_ar) ? 16'd0 : m_cnt + 16'd1;
            if (wr && ma != 16'hFFFF) begin
                idx = int'(ma) - 'hFFF0;
                if (idx >= 0 && idx < ND) m_disp[idx] = i_data[7:0];
                case (ma)
                    16'hFFE0: m_cnt = i_data[15:0];
                    16'hFFE1: m_cmp = i_data[15:0];
                    16'hFFE2: {m_ie, m_ar, m_en} = i_data[2:0];
                    16'hFFE3: if (i_data[0]) m_flag = 0;
                    default: ;
                endcase
            end
            if (hit) m_flag = 1;
            m_irq = nirq;
            unm = wr && !mp;
            if (m_resp) begin
                m_resp = 0;
            end else if (m_wait_rx) begin
                if (i_uart_rd_valid) begin
                    m_data = 32'(i_uart_data);
                    m_wait_rx = 0;
                    m_resp = 1;
                end
            end else if (i_rd_ready && !wr) begin
                if (ma == 16'hFFFE) begin
                    m_wait_rx = 1;
                end else begin
                    m_data = rv;
                    m_resp = 1;
                    unm = unm || !mp;
                end
            end
            m_unm = unm;
        end
    end

    always @(negedge i_clk) begin
        logic [15:0] ca;
        logic [ND*8-1:0] e_disp;
        ca = i_addr[15:0];
        for (int k = 0; k < ND; k++) e_disp[8*k +: 8] = m_disp[k];
        chk("wr_ready", o_wr_ready, (ca == 16'hFFFF) ? i_uart_wr_ready : i_wr_valid);
        chk("uart_wr_valid", o_uart_wr_valid, i_wr_valid && (ca == 16'hFFFF));
        if (i_wr_valid && ca == 16'hFFFF) chk("uart_data", o_uart_data, i_data[7:0]);
        chk("uart_rd_ready", o_uart_rd_ready, m_wait_rx);
        chk("rd_valid", o_rd_valid, m_resp);
        chk("rd_data", o_data, m_data);
        chk("disp_regs", o_disp_regs, e_disp);
        chk("timer_irq", o_timer_irq, m_irq);
        chk("unmapped", o_unmapped, m_unm);
    end

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        i_addr = {16'h0, a};
        i_data = d;
        i_wr_valid = 1'b1;
        @(posedge i_clk); #1;
        i_wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic v, output logic [31:0] d, output logic u);
        i_addr = {16'h0, a};
        i_rd_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rd_ready = 1'b0;
        #1;
        v = o_rd_valid;
        d = o_data;
        u = o_unmapped;
        @(posedge i_clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] alist [14];

    initial begin
        logic v, u;
        logic [31:0] d;
        bit hold;
        int hold_cnt, op;
        logic [15:0] pa;

        alist = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFF0, 16'hFFF1, 16'hFFF2, 16'hFFF3,
                  16'hFFE0, 16'hFFE1, 16'hFFE2, 16'hFFE3, 16'hFFE4, 16'hFFDF, 16'h1234};
        i_rst = 1'b1; i_addr = 0; i_data = 0; i_wr_valid = 0; i_rd_ready = 0;
        i_uart_wr_ready = 0; i_uart_tx_free = 0; i_uart_rx_present = 0;
        i_uart_data = 0; i_uart_rd_valid = 0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        #1;
        chk("rst_data", o_data, 0);
        chk("rst_rd_valid", o_rd_valid, 0);
        chk("rst_disp", o_disp_regs, 0);
        chk("rst_irq", o_timer_irq, 0);
        chk("rst_unmapped", o_unmapped, 0);

        // Display register write then read-back
        i_addr = 32'hFFF1; i_data = 32'h0000_00A5; i_wr_valid = 1'b1; #1;
        chk("disp_wr_ready", o_wr_ready, 1);
        @(posedge i_clk); #1;
        i_wr_valid = 1'b0;
        chk("disp1_value", o_disp_regs[15:8], 8'hA5);
        rd(16'hFFF1, v, d, u);
        chk("disp_rd_valid", v, 1);
        chk("disp_rd_data", d, 32'hA5);
        chk("disp_rd_unmapped", u, 0);

        // RX read with a 5-cycle wait for the UART byte
        i_addr = 32'hFFFE; i_rd_ready = 1'b1; i_uart_rd_valid = 1'b0;
        @(posedge i_clk); #1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rx_wait_rd_ready", o_uart_rd_ready, 1);
            chk("rx_wait_no_valid", o_rd_valid, 0);
            @(posedge i_clk); #1;
        end
        i_uart_rd_valid = 1'b1; i_uart_data = 8'h3C;
        @(posedge i_clk); #1;
        i_uart_rd_valid = 1'b0; i_rd_ready = 1'b0;
        chk("rx_rd_valid", o_rd_valid, 1);
        chk("rx_rd_data", o_data, 32'h3C);
        chk("rx_rd_ready_drop", o_uart_rd_ready, 0);
        @(posedge i_clk); #1;

        // Compare match on the 4th tick with auto-reload and interrupt
        wr(16'hFFE1, 32'd3);
        wr(16'hFFE0, 32'd0);
        wr(16'hFFE2, 32'd7);
        repeat (16) @(posedge i_clk);
        #2;
        chk("irq_before_lag", o_timer_irq, 0);
        @(posedge i_clk); #2;
        chk("irq_after_match", o_timer_irq, 1);
        rd(16'hFFE0, v, d, u);
        chk("count_reloaded", d, 0);
        wr(16'hFFE3, 32'd1);
        @(posedge i_clk); #2;
        chk("irq_cleared", o_timer_irq, 0);
        wr(16'hFFE2, 32'd0);

        // Count write landing on a tick edge
        wr(16'hFFE2, 32'd1);
        repeat (3) @(posedge i_clk);
        #1;
        wr(16'hFFE0, 32'h100);
        wr(16'hFFE2, 32'd0);
        rd(16'hFFE0, v, d, u);
        chk("count_write_wins", d, 32'h100);

        // UART TX backpressure
        i_addr = 32'hFFFF; i_data = 32'h5A; i_wr_valid = 1'b1; i_uart_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("tx_stall_ready", o_wr_ready, 0);
            chk("tx_stall_valid", o_uart_wr_valid, 1);
            chk("tx_stall_data", o_uart_data, 8'h5A);
            @(posedge i_clk); #1;
        end
        i_uart_wr_ready = 1'b1; #1;
        chk("tx_accept_ready", o_wr_ready, 1);
        @(posedge i_clk); #1;
        i_wr_valid = 1'b0; i_uart_wr_ready = 1'b0;

        // Unmapped reads
        rd(16'h1234, v, d, u);
        chk("unm1_valid", v, 1);
        chk("unm1_data", d, 0);
        chk("unm1_flag", u, 1);
        #1 chk("unm1_flag_clear", o_unmapped, 0);
        rd(16'hFFF0 + 16'(ND), v, d, u);
        chk("unm2_valid", v, 1);
        chk("unm2_data", d, 0);
        chk("unm2_flag", u, 1);

        // Reset during the response cycle
        i_addr = 32'hFFF1; i_rd_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rd_ready = 1'b0;
        chk("pre_rst_valid", o_rd_valid, 1);
        i_rst = 1'b1; #1;
        chk("rst_resp_valid", o_rd_valid, 0);
        chk("rst_resp_data", o_data, 0);
        chk("rst_resp_disp", o_disp_regs, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Randomized traffic against the model
        hold = 0; hold_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            i_uart_wr_ready   = 1'($urandom_range(0, 1));
            i_uart_tx_free    = (TFD + 1)'($urandom);
            i_uart_rx_present = 1'($urandom_range(0, 1));
            i_uart_data       = 8'($urandom);
            i_uart_rd_valid   = ($urandom_range(0, 3) == 0);
            if (hold) begin
                hold_cnt++;
                if (o_rd_valid) begin
                    hold = 0;
                    i_rd_ready = 1'b0;
                end else if (hold_cnt > 200) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_timeout: no o_rd_valid after %0d cycles", hold_cnt);
                    hold = 0;
                    i_rd_ready = 1'b0;
                end
            end else begin
                i_wr_valid = 1'b0;
                i_rd_ready = 1'b0;
                pa = alist[$urandom_range(0, 13)];
                if (pa == 16'h1234) pa = 16'($urandom);
                i_addr = {16'($urandom), pa};
                i_data = $urandom;
                if (pa == 16'hFFE0) begin
                    case ($urandom_range(0, 3))
                        0: i_data[15:0] = 16'hFFFF;
                        1: i_data[15:0] = 16'hFFFE;
                        default: i_data[15:0] = 16'($urandom_range(0, 12));
                    endcase
                end
                if (pa == 16'hFFE1) i_data[15:0] = 16'($urandom_range(0, 12));
                op = $urandom_range(0, 9);
                if (op < 4) begin
                    i_wr_valid = 1'b1;
                end else if (op < 8) begin
                    i_rd_ready = 1'b1;
                    hold = 1;
                    hold_cnt = 0;
                end else if (op == 8) begin
                    i_wr_valid = 1'b1;
                    i_rd_ready = 1'b1;
                end
            end
            @(posedge i_clk); #1;
        end
        i_wr_valid = 1'b0;
        i_rd_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
